instr_trace_buf: RTL

INSTR_TRACE_BUF -- requirements
Module: instr_trace_buf

---
 rtl/instr_trace_buf_if.sv | 16 +
 rtl/instr_trace_buf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_trace_buf_if.sv
// Retire-side push bus and trace-side pop bus of the instruction trace buffer.
interface instr_trace_buf_if #(parameter int PC_W = 32);
  logic            ret_valid;
  logic [PC_W-1:0] ret_pc;
  logic [31:0]     ret_instr;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [63:0]     out_ascii;

  modport master (output ret_valid, ret_pc, ret_instr, out_ready,
                  input  out_valid, out_pc, out_instr, out_ascii);
  modport slave  (input  ret_valid, ret_pc, ret_instr, out_ready,
                  output out_valid, out_pc, out_instr, out_ascii);
endinterface

// File: rtl/instr_trace_buf.sv
// Retired-instruction trace FIFO with MIPS32 mnemonic decode (drop-newest or overwrite-oldest).
// Optional per-class retire counters enabled by macro TRACE_CLASS_CNT_EN.
module instr_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
  parameter int PC_W      = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  instr_trace_buf_if.slave         trc,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              retire_cnt,
  output logic [31:0]              drop_cnt
`ifdef TRACE_CLASS_CNT_EN
  ,
  output logic [31:0]              cnt_alu,
  output logic [31:0]              cnt_mem,
  output logic [31:0]              cnt_br,
  output logic [31:0]              cnt_priv
`endif
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int EW  = PC_W + 32 + 64;
  localparam bit OVW = (WRAP_MODE != 0);

  typedef enum logic [2:0] {C_ALU, C_MEM, C_BR, C_PRIV, C_NR} cls_e;
  typedef struct packed {
    logic [63:0] asc;
    cls_e        cls;
  } dec_t;

  function automatic dec_t mk(input logic [63:0] a, input cls_e c);
    dec_t r;
    r.asc = a;
    r.cls = c;
    return r;
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = mk(64'("N-R"), C_NR);
    if (ins == 32'h0)              d = mk(64'("NOP"), C_ALU);
    else if (ins == 32'h42000018)  d = mk(64'("ERET"), C_PRIV);
    else begin
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h00: d = mk(64'("SLL"), C_ALU);
          6'h02: d = mk(64'("SRL"), C_ALU);
          6'h03: d = mk(64'("SRA"), C_ALU);
          6'h04: d = mk(64'("SLLV"), C_ALU);
          6'h06: d = mk(64'("SRLV"), C_ALU);
          6'h07: d = mk(64'("SRAV"), C_ALU);
          6'h08: d = mk(64'("JR"), C_BR);
          6'h09: d = mk(64'("JALR"), C_BR);
          6'h0C: d = mk(64'("SYSCALL"), C_PRIV);
          6'h0D: d = mk(64'("BREAK"), C_PRIV);
          6'h10: d = mk(64'("MFHI"), C_ALU);
          6'h11: d = mk(64'("MTHI"), C_ALU);
          6'h12: d = mk(64'("MFLO"), C_ALU);
          6'h13: d = mk(64'("MTLO"), C_ALU);
          6'h18: d = mk(64'("MULT"), C_ALU);
          6'h19: d = mk(64'("MULTU"), C_ALU);
          6'h1A: d = mk(64'("DIV"), C_ALU);
          6'h1B: d = mk(64'("DIVU"), C_ALU);
          6'h20: d = mk(64'("ADD"), C_ALU);
          6'h21: d = mk(64'("ADDU"), C_ALU);
          6'h22: d = mk(64'("SUB"), C_ALU);
          6'h23: d = mk(64'("SUBU"), C_ALU);
          6'h24: d = mk(64'("AND"), C_ALU);
          6'h25: d = mk(64'("OR"), C_ALU);
          6'h26: d = mk(64'("XOR"), C_ALU);
          6'h27: d = mk(64'("NOR"), C_ALU);
          6'h2A: d = mk(64'("SLT"), C_ALU);
          6'h2B: d = mk(64'("SLTU"), C_ALU);
          default: ;
        endcase
        6'h01: case (ins[20:16])
          5'h00: d = mk(64'("BLTZ"), C_BR);
          5'h01: d = mk(64'("BGEZ"), C_BR);
          5'h10: d = mk(64'("BLTZAL"), C_BR);
          5'h11: d = mk(64'("BGEZAL"), C_BR);
          default: ;
        endcase
        6'h02: d = mk(64'("J"), C_BR);
        6'h03: d = mk(64'("JAL"), C_BR);
        6'h04: d = mk(64'("BEQ"), C_BR);
        6'h05: d = mk(64'("BNE"), C_BR);
        6'h06: d = mk(64'("BLEZ"), C_BR);
        6'h07: d = mk(64'("BGTZ"), C_BR);
        6'h08: d = mk(64'("ADDI"), C_ALU);
        6'h09: d = mk(64'("ADDIU"), C_ALU);
        6'h0A: d = mk(64'("SLTI"), C_ALU);
        6'h0B: d = mk(64'("SLTIU"), C_ALU);
        6'h0C: d = mk(64'("ANDI"), C_ALU);
        6'h0D: d = mk(64'("ORI"), C_ALU);
        6'h0E: d = mk(64'("XORI"), C_ALU);
        6'h0F: d = mk(64'("LUI"), C_ALU);
        6'h10: case (ins[25:21])
          5'h04: d = mk(64'("MTC0"), C_PRIV);
          5'h00: d = mk(64'("MFC0"), C_PRIV);
          default: ;
        endcase
        6'h20: d = mk(64'("LB"), C_MEM);
        6'h21: d = mk(64'("LH"), C_MEM);
        6'h23: d = mk(64'("LW"), C_MEM);
        6'h24: d = mk(64'("LBU"), C_MEM);
        6'h25: d = mk(64'("LHU"), C_MEM);
        6'h28: d = mk(64'("SB"), C_MEM);
        6'h29: d = mk(64'("SH"), C_MEM);
        6'h2B: d = mk(64'("SW"), C_MEM);
        default: ;
      endcase
    end
    return d;
  endfunction

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [31:0]   ret_q, ret_d, drop_q, drop_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic          full, pop, drop, wr_en, rd_adv;
  dec_t          dec;

  assign dec    = decode(trc.ret_instr);
  assign full   = (lvl_q == LW'(DEPTH));
  assign pop    = (lvl_q != '0) && trc.out_ready;
  assign drop   = trc.ret_valid && full && !pop;
  // In overwrite mode a full push still writes; the head steps past the clobbered entry.
  assign wr_en  = trc.ret_valid && (!drop || OVW);
  assign rd_adv = pop || (drop && OVW);

  always_comb begin
    wr_d   = wr_q + AW'(wr_en);
    rd_d   = rd_q + AW'(rd_adv);
    lvl_d  = lvl_q + LW'(wr_en) - LW'(rd_adv);
    ret_d  = ret_q + 32'(trc.ret_valid);
    drop_d = (drop && drop_q != '1) ? drop_q + 32'd1 : drop_q;
    if (clear) begin
      wr_d   = '0;
      rd_d   = '0;
      lvl_d  = '0;
      ret_d  = '0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      ret_q  <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      ret_q  <= ret_d;
      drop_q <= drop_d;
    end
  end

  // Storage is not reset: contents are only visible through the level-gated outputs.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem_q[wr_q] <= {trc.ret_pc, trc.ret_instr, dec.asc};
  end

  assign head          = mem_q[rd_q];
  assign trc.out_valid = (lvl_q != '0);
  assign trc.out_pc    = trc.out_valid ? head[EW-1 -: PC_W] : '0;
  assign trc.out_instr = trc.out_valid ? head[95:64] : '0;
  assign trc.out_ascii = trc.out_valid ? head[63:0] : '0;
  assign level         = lvl_q;
  assign retire_cnt    = ret_q;
  assign drop_cnt      = drop_q;

`ifdef TRACE_CLASS_CNT_EN
  logic [31:0] alu_q, alu_d, mem_cq, mem_cd, br_q, br_d, priv_q, priv_d;

  always_comb begin
    alu_d  = alu_q  + 32'(trc.ret_valid && dec.cls == C_ALU);
    mem_cd = mem_cq + 32'(trc.ret_valid && dec.cls == C_MEM);
    br_d   = br_q   + 32'(trc.ret_valid && dec.cls == C_BR);
    priv_d = priv_q + 32'(trc.ret_valid && dec.cls == C_PRIV);
    if (clear) begin
      alu_d  = '0;
      mem_cd = '0;
      br_d   = '0;
      priv_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_q  <= '0;
      mem_cq <= '0;
      br_q   <= '0;
      priv_q <= '0;
    end else begin
      alu_q  <= alu_d;
      mem_cq <= mem_cd;
      br_q   <= br_d;
      priv_q <= priv_d;
    end
  end

  assign cnt_alu  = alu_q;
  assign cnt_mem  = mem_cq;
  assign cnt_br   = br_q;
  assign cnt_priv = priv_q;
`endif
endmodule
